// File: rtl/clkdiv_prog.sv
// clkdiv_prog: runtime-programmable clock divider / clock-enable generator.
// A new divisor/high-time is captured into a shadow pair by load and only
// takes effect at a period boundary (wrap or sync_clr), so clk_out never
// produces a runt pulse while being reprogrammed.
//
// Ports:
//   clk_in    system clock, rising edge
//   rst_n     asynchronous active-low reset
//   en        count enable; low freezes counter and clk_out
//   sync_clr  synchronous period restart, independent of en
//   load      one-cycle request to capture div_in/high_in into the shadow pair
//   div_in    requested divisor (0 is treated as 1)
//   high_in   requested high-time in cycles
//   clk_out   registered divided clock
//   tick      registered one-cycle pulse on the first cycle of each period
//   pending   a captured load is waiting for the next period boundary
//   cnt_out   current phase counter
module clkdiv_prog #(
  parameter int unsigned CNT_WIDTH    = 8,
  parameter int unsigned DEFAULT_DIV  = 4,
  parameter int unsigned DEFAULT_HIGH = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 sync_clr,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] div_in,
  input  logic [CNT_WIDTH-1:0] high_in,
  output logic                 clk_out,
  output logic                 tick,
  output logic                 pending,
  output logic [CNT_WIDTH-1:0] cnt_out
);

  localparam logic [CNT_WIDTH-1:0] RST_DIV  = CNT_WIDTH'(DEFAULT_DIV);
  localparam logic [CNT_WIDTH-1:0] RST_HIGH = CNT_WIDTH'(DEFAULT_HIGH);
  localparam logic [CNT_WIDTH-1:0] RST_CNT  = CNT_WIDTH'(DEFAULT_DIV - 1);
  localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] act_div,  act_div_nxt;
  logic [CNT_WIDTH-1:0] act_high, act_high_nxt;
  logic [CNT_WIDTH-1:0] sh_div,   sh_div_nxt;
  logic [CNT_WIDTH-1:0] sh_high,  sh_high_nxt;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic                 pending_nxt;
  logic                 clk_out_nxt;
  logic                 tick_nxt;
  logic                 wrap;
  logic                 restart;
  logic                 apply;

  // Next-state logic for counter, shadow/active pairs and outputs.
  always_comb begin
    cnt_nxt      = cnt_out;
    act_div_nxt  = act_div;
    act_high_nxt = act_high;
    sh_div_nxt   = sh_div;
    sh_high_nxt  = sh_high;
    pending_nxt  = pending;
    clk_out_nxt  = clk_out;
    tick_nxt     = 1'b0;

    wrap    = en && (cnt_out == (act_div - ONE));
    restart = sync_clr || wrap;
    // Shadow is applied from its pre-edge value, so a load on a boundary
    // edge is deferred to the following boundary.
    apply   = restart && pending;

    if (sync_clr || wrap) begin
      cnt_nxt = '0;
    end else if (en) begin
      cnt_nxt = cnt_out + ONE;
    end

    if (apply) begin
      act_div_nxt  = sh_div;
      act_high_nxt = sh_high;
      pending_nxt  = 1'b0;
    end

    if (load) begin
      sh_div_nxt  = (div_in == '0) ? ONE : div_in;
      sh_high_nxt = high_in;
      pending_nxt = 1'b1;
    end

    // clk_out only moves on edges that advance the counter, using the
    // active pair in force after the edge.
    if (sync_clr || en) begin
      clk_out_nxt = (cnt_nxt < act_high_nxt);
    end

    tick_nxt = restart;
  end

  // State and output registers.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_out  <= RST_CNT;
      act_div  <= RST_DIV;
      act_high <= RST_HIGH;
      sh_div   <= RST_DIV;
      sh_high  <= RST_HIGH;
      pending  <= 1'b0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
    end else begin
      cnt_out  <= cnt_nxt;
      act_div  <= act_div_nxt;
      act_high <= act_high_nxt;
      sh_div   <= sh_div_nxt;
      sh_high  <= sh_high_nxt;
      pending  <= pending_nxt;
      clk_out  <= clk_out_nxt;
      tick     <= tick_nxt;
    end
  end

endmodule

// File: tb/tb_clkdiv_prog.sv
// Testbench for clkdiv_prog: directed per-cycle vectors with hand-computed
// expected outputs pushed to a scoreboard queue; a monitor pops and compares
// after every rising edge.
module tb_clkdiv_prog;

  localparam int unsigned W = 8;

  logic         clk_in = 1'b0;
  logic         rst_n;
  logic         en;
  logic         sync_clr;
  logic         load;
  logic [W-1:0] div_in;
  logic [W-1:0] high_in;
  logic         clk_out;
  logic         tick;
  logic         pending;
  logic [W-1:0] cnt_out;

  logic [W+2:0] exp_q[$];
  int           idx_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           vec   = 0;

  clkdiv_prog #(.CNT_WIDTH(W), .DEFAULT_DIV(4), .DEFAULT_HIGH(2)) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .en       (en),
    .sync_clr (sync_clr),
    .load     (load),
    .div_in   (div_in),
    .high_in  (high_in),
    .clk_out  (clk_out),
    .tick     (tick),
    .pending  (pending),
    .cnt_out  (cnt_out)
  );

  always #5 clk_in = ~clk_in;

  // Drive one cycle of inputs and queue the state expected after the edge.
  task automatic step(input logic r, input logic e, input logic c,
                      input logic l, input int d, input int h,
                      input logic x_clk, input logic x_tick,
                      input logic x_pend, input int x_cnt);
    @(negedge clk_in);
    rst_n    = r;
    en       = e;
    sync_clr = c;
    load     = l;
    div_in   = W'(d);
    high_in  = W'(h);
    exp_q.push_back({x_clk, x_tick, x_pend, W'(x_cnt)});
    idx_q.push_back(vec);
    vec++;
  endtask

  // Monitor: compare DUT outputs against the scoreboard after each edge.
  initial begin
    logic [W+2:0] e;
    logic [W+2:0] a;
    int           i;
    forever begin
      @(posedge clk_in);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        i = idx_q.pop_front();
        a = {clk_out, tick, pending, cnt_out};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL vec%0d: got clk=%b tick=%b pend=%b cnt=%0d, want clk=%b tick=%b pend=%b cnt=%0d",
                   i, a[W+2], a[W+1], a[W], a[W-1:0], e[W+2], e[W+1], e[W], e[W-1:0]);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; sync_clr = 1'b0; load = 1'b0;
    div_in = '0; high_in = '0;

    //     rst en clr ld div hi  clk tk pd cnt
    step(0, 0, 0, 0, 0, 0,  0, 0, 0, 3);   // reset state
    step(1, 1, 0, 0, 0, 0,  1, 1, 0, 0);   // first enabled edge wraps
    step(1, 1, 0, 0, 0, 0,  1, 0, 0, 1);
    step(1, 1, 0, 1, 6, 1,  0, 0, 1, 2);   // load 6/1 at cnt=1
    step(1, 1, 0, 0, 0, 0,  0, 0, 1, 3);
    step(1, 1, 0, 0, 0, 0,  1, 1, 0, 0);   // 6/1 applied at wrap
    step(1, 1, 0, 0, 0, 0,  0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0,  0, 0, 0, 2);
    step(1, 1, 0, 0, 0, 0,  0, 0, 0, 3);
    step(1, 1, 0, 0, 0, 0,  0, 0, 0, 4);
    step(1, 1, 0, 0, 0, 0,  0, 0, 0, 5);
    step(1, 1, 0, 0, 0, 0,  1, 1, 0, 0);   // period 6
    step(1, 1, 0, 1, 0, 1,  0, 0, 1, 1);   // load 0/1 -> div 1
    step(1, 1, 0, 0, 0, 0,  0, 0, 1, 2);
    step(1, 1, 0, 0, 0, 0,  0, 0, 1, 3);
    step(1, 1, 0, 0, 0, 0,  0, 0, 1, 4);
    step(1, 1, 0, 0, 0, 0,  0, 0, 1, 5);
    step(1, 1, 0, 0, 0, 0,  1, 1, 0, 0);   // div 1 high 1: constant 1
    step(1, 1, 0, 0, 0, 0,  1, 1, 0, 0);
    step(1, 1, 0, 1, 1, 0,  1, 1, 1, 0);   // load on wrap edge defers
    step(1, 1, 0, 0, 0, 0,  0, 1, 0, 0);   // div 1 high 0: constant 0
    step(1, 1, 0, 0, 0, 0,  0, 1, 0, 0);
    step(1, 1, 0, 1, 4, 2,  0, 1, 1, 0);
    step(1, 1, 0, 0, 0, 0,  1, 1, 0, 0);   // back to 4/2
    step(1, 1, 0, 0, 0, 0,  1, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0,  0, 0, 0, 2);
    step(1, 0, 0, 0, 0, 0,  0, 0, 0, 2);   // freeze 3 cycles
    step(1, 0, 0, 0, 0, 0,  0, 0, 0, 2);
    step(1, 0, 0, 0, 0, 0,  0, 0, 0, 2);
    step(1, 1, 0, 0, 0, 0,  0, 0, 0, 3);
    step(1, 1, 0, 0, 0, 0,  1, 1, 0, 0);   // stretched period of 7
    step(1, 1, 0, 0, 0, 0,  1, 0, 0, 1);
    step(1, 1, 0, 1, 3, 1,  0, 0, 1, 2);   // load 3/1
    step(1, 1, 1, 0, 0, 0,  1, 1, 0, 0);   // sync_clr at cnt=2 applies it
    step(1, 1, 0, 0, 0, 0,  0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0,  0, 0, 0, 2);
    step(1, 1, 0, 0, 0, 0,  1, 1, 0, 0);   // period 3
    step(1, 1, 0, 1, 4, 2,  0, 0, 1, 1);
    step(1, 0, 1, 0, 0, 0,  1, 1, 0, 0);   // sync_clr with en=0
    step(1, 0, 0, 0, 0, 0,  1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0,  1, 0, 0, 1);
    step(1, 1, 0, 1, 6, 1,  0, 0, 1, 2);   // pending 6/1 then reset
    step(0, 1, 0, 0, 0, 0,  0, 0, 0, 3);
    step(1, 1, 0, 0, 0, 0,  1, 1, 0, 0);
    step(1, 1, 0, 0, 0, 0,  1, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0,  0, 0, 0, 2);
    step(1, 1, 0, 0, 0, 0,  0, 0, 0, 3);
    step(1, 1, 0, 0, 0, 0,  1, 1, 0, 0);   // discarded load never applies
    step(1, 1, 0, 0, 0, 0,  1, 0, 0, 1);

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk_in);
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
